// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters
// (core data port, host/debug port) and the single-port memory array.
//
// Handshakes:
//   core : cpu_en marks an access this cycle; it is performed only when
//          cpu_stall=0, otherwise the core holds the same access next cycle.
//   host : host_req is raised with host_we/addr/wdata stable and held until
//          host_ack; host_ack is a one-cycle pulse, host_rdata is valid with
//          it and held until the next completion.
interface dmem_port_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          cpu_en;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          busy_clear;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, host_ack, host_rdata, busy_clear,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, host_ack, host_rdata, busy_clear,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port access controller for the variable data memory. After reset it
// zero-fills the array while stalling the core, then arbitrates each cycle
// between the core (priority) and the host, with a starvation guard that
// forces a host slot after STARVE_LIMIT consecutive denials.
module dmem_port_arbiter #(
  parameter int DEPTH          = 128,
  parameter int DW             = 32,
  parameter int STARVE_LIMIT   = 8,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  dmem_port_arbiter_if.slave bus,
  output logic               state_dbg,
  output logic [CW-1:0]      wait_cnt_dbg,
  output logic               force_dbg
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_HOST, OWN_FORCE} owner_t;

  localparam state_t        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LIMIT       = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1    = CW'(STARVE_LIMIT - 1);

  state_t        state_q, state_d;
  owner_t        owner;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [CW-1:0] wait_cnt_q;
  logic          force_q;
  logic          host_ack_q;
  logic [DW-1:0] host_rdata_q;
  logic          host_pend;
  logic          host_grant;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic [DW-1:0] cpu_rdata_c;

  // The ack cycle does not count as pending, so the host cannot be re-granted
  // before it has seen its completion.
  assign host_pend  = bus.host_req & ~host_ack_q;
  assign host_grant = (owner == OWN_HOST) | (owner == OWN_FORCE);

  // State register and sweep address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state, per-cycle owner and memory-port mux.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    owner       = OWN_IDLE;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    cpu_rdata_c = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c   = 1'b1;
        mem_addr_c = clr_addr_q;
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = ST_RUN;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: begin
        // A stalled core never owns the port, even if the host dropped out.
        if (host_pend && force_q)       owner = OWN_FORCE;
        else if (bus.cpu_en && !force_q) owner = OWN_CPU;
        else if (host_pend)              owner = OWN_HOST;
        else                             owner = OWN_IDLE;
        case (owner)
          OWN_CPU: begin
            mem_we_c    = bus.cpu_we;
            mem_addr_c  = bus.cpu_addr;
            mem_wdata_c = bus.cpu_wdata;
            cpu_rdata_c = bus.mem_rdata;
          end
          OWN_HOST, OWN_FORCE: begin
            mem_we_c    = bus.host_we;
            mem_addr_c  = bus.host_addr;
            mem_wdata_c = bus.host_wdata;
          end
          default: ;
        endcase
      end
    endcase
  end

  // Host completion and starvation guard.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      wait_cnt_q   <= '0;
      force_q      <= 1'b0;
    end else begin
      host_ack_q <= host_grant;
      if (host_grant) host_rdata_q <= bus.mem_rdata;
      if (!bus.host_req || host_grant) begin
        wait_cnt_q <= '0;
        force_q    <= 1'b0;
      end else if (host_pend && (wait_cnt_q != LIMIT)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
        if (wait_cnt_q == LIMIT_M1) force_q <= 1'b1;
      end
    end
  end

  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.cpu_rdata  = cpu_rdata_c;
  assign bus.cpu_stall  = (state_q == ST_CLEAR) | force_q;
  assign bus.busy_clear = (state_q == ST_CLEAR);
  assign bus.host_ack   = host_ack_q;
  assign bus.host_rdata = host_rdata_q;

  assign state_dbg    = (state_q == ST_RUN);
  assign wait_cnt_dbg = wait_cnt_q;
  assign force_dbg    = force_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a behavioural memory array, a shadow model of
// the memory contents, expected-response queues for host completions and
// core reads, directed scenarios and a randomized concurrent phase.
module tb_dmem_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int LIMIT = 8;
  localparam int CW = $clog2(LIMIT + 1);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic preload = 1'b1;
  always #5 CLK = ~CLK;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  logic          state_dbg, force_dbg, state_dbg0, force_dbg0;
  logic [CW-1:0] wait_cnt_dbg, wait_cnt_dbg0;

  dmem_port_arbiter #(.DEPTH(DEPTH), .DW(DW), .STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg), .force_dbg(force_dbg)
  );

  dmem_port_arbiter #(.DEPTH(DEPTH), .DW(DW), .STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(bus0),
    .state_dbg(state_dbg0), .wait_cnt_dbg(wait_cnt_dbg0), .force_dbg(force_dbg0)
  );

  // ---------------- memory arrays ----------------
  logic [DW-1:0] tb_mem [DEPTH];
  logic [DW-1:0] tb_mem0 [DEPTH];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 32'hDEADBEEF;
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  always @(posedge CLK) if (bus0.mem_we) tb_mem0[bus0.mem_addr] <= bus0.mem_wdata;
  assign bus0.mem_rdata = tb_mem0[bus0.mem_addr];

  // ---------------- model / scoreboard ----------------
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] host_exp_q[$];
  logic [DW-1:0] cpu_exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  // Monitor: host completions and core reads against the expected queues.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.host_ack) begin
        if (host_exp_q.size() == 0) check("host_unexpected_ack", 1, 0);
        else check("host_rdata", bus.host_rdata, host_exp_q.pop_front());
      end
      if (bus.cpu_en && !bus.cpu_we && !bus.cpu_stall) begin
        if (cpu_exp_q.size() == 0) check("cpu_unexpected_read", 1, 0);
        else check("cpu_rdata", bus.cpu_rdata, cpu_exp_q.pop_front());
      end else if (!(bus.cpu_en && !bus.cpu_stall)) begin
        check("cpu_rdata_zero", bus.cpu_rdata, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_host_ack", bus.host_ack, 0);
    check("rst_host_rdata", bus.host_rdata, 0);
    check("rst_busy_clear", bus.busy_clear, 1);
    check("rst_cpu_stall", bus.cpu_stall, 1);
    check("rst_mem_we", bus.mem_we, 1);
    check("rst_wait_force", {wait_cnt_dbg, force_dbg}, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    preload = 1'b0;
  endtask

  // Called right after reset release: expects DEPTH sweep cycles, then RUN.
  task automatic check_sweep();
    int bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge CLK);
      if (!(bus.mem_we && bus.busy_clear && bus.cpu_stall && bus.mem_addr == AW'(k) && bus.mem_wdata == 0)) begin
        bad++;
        if (bad < 4) check("sweep_cycle", {bus.mem_we, bus.busy_clear, 1'b0, bus.mem_addr}, {2'b11, 1'b0, 7'(k)});
      end
    end
    check("sweep_bad_cycles", bad, 0);
    @(negedge CLK);
    check("sweep_done_busy", bus.busy_clear, 0);
    check("sweep_done_stall", bus.cpu_stall, 0);
    check("sweep_done_we", bus.mem_we, 0);
    clear_model();
  endtask

  task automatic cpu_access(input logic we, input int addr, input logic [DW-1:0] data);
    int guard = 0;
    @(posedge CLK); #1;
    bus.cpu_en = 1'b1; bus.cpu_we = we; bus.cpu_addr = AW'(addr); bus.cpu_wdata = data;
    if (!we) cpu_exp_q.push_back(exp_mem[addr]);
    @(negedge CLK);
    while (bus.cpu_stall && guard < 40) begin
      guard++;
      @(negedge CLK);
    end
    if (guard >= 40) check("cpu_stall_timeout", 1, 0);
    if (we) exp_mem[addr] = data;
    @(posedge CLK); #1;
    bus.cpu_en = 1'b0;
  endtask

  // Returns cycles from first req cycle to ack cycle and mem_we seen in the ack cycle.
  task automatic host_xact(input logic we, input int addr, input logic [DW-1:0] data,
                           output int lat, output logic ack_we);
    int n = 0;
    ack_we = 1'b0;
    @(posedge CLK); #1;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = AW'(addr); bus.host_wdata = data;
    host_exp_q.push_back(exp_mem[addr]);
    if (we) exp_mem[addr] = data;
    forever begin
      @(negedge CLK);
      n++;
      if (bus.host_ack) break;
      if (n > 40) begin
        check("host_ack_timeout", 1, 0);
        break;
      end
    end
    lat = n - 1;
    ack_we = bus.mem_we;
    @(posedge CLK); #1;
    bus.host_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic ack_we;
    logic [DW-1:0] d;
    bus.cpu_en = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus0.cpu_en = 0; bus0.cpu_we = 0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.host_req = 0; bus0.host_we = 0; bus0.host_addr = '0; bus0.host_wdata = '0;
    clear_model();

    // Sweep over preloaded memory, then every word must read back zero.
    do_reset();
    check_sweep();
    check("run_state", state_dbg, 1);
    for (int a = 0; a < DEPTH; a++) cpu_access(1'b0, a, '0);

    // Host write then read with an idle core.
    host_xact(1'b1, 5, 32'h12345678, lat, ack_we);
    check("hw_latency", lat, 1);
    check("hw_ack_cycle_we", ack_we, 0);
    host_xact(1'b0, 5, '0, lat, ack_we);
    check("hr_latency", lat, 1);
    @(negedge CLK);
    check("hr_ack_single", bus.host_ack, 0);
    check("hr_rdata_held", bus.host_rdata, 32'h12345678);

    // Core write observed by host; core write then host write, later wins.
    cpu_access(1'b1, 10, 32'hA5A5A5A5);
    host_xact(1'b0, 10, '0, lat, ack_we);
    cpu_access(1'b1, 11, 32'h11111111);
    host_xact(1'b1, 11, 32'h22222222, lat, ack_we);
    cpu_access(1'b0, 11, '0);
    cpu_access(1'b0, 10, '0);

    // Starvation: core busy every cycle, host read of addr 3 pending.
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      bus.cpu_en = 1'b1; bus.cpu_we = 1'b1;
      if (c == 9) begin
        bus.cpu_addr = AW'(21); bus.cpu_wdata = 32'hBAD0BAD0;
      end else begin
        bus.cpu_addr = AW'(20); bus.cpu_wdata = 32'hC0DE0000 + c;
        exp_mem[20] = 32'hC0DE0000 + c;
      end
      if (c == 1) begin
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = AW'(3);
        host_exp_q.push_back(exp_mem[3]);
      end
      @(negedge CLK);
      check($sformatf("starve_stall_c%0d", c), bus.cpu_stall, c == 9);
      check($sformatf("starve_ack_c%0d", c), bus.host_ack, c == 10);
      check($sformatf("starve_port_c%0d", c), {bus.mem_we, bus.mem_addr},
            (c == 9) ? {1'b0, 7'd3} : {1'b1, 7'd20});
    end
    @(posedge CLK); #1;
    bus.cpu_en = 1'b0; bus.host_req = 1'b0;
    @(negedge CLK);
    check("starve_wait_cleared", {wait_cnt_dbg, force_dbg}, 0);
    cpu_access(1'b0, 20, '0);
    cpu_access(1'b0, 21, '0);

    // Reset mid-sweep at address 60 restarts a full sweep.
    host_xact(1'b1, 2, 32'hCAFE0001, lat, ack_we);
    host_xact(1'b0, 2, '0, lat, ack_we);
    do_reset();
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (bus.mem_addr != AW'(60) && lat < 300);
    check("midsweep_reached_60", bus.mem_addr, 60);
    RESET = 1'b1;
    #1;
    check("midsweep_rst_addr", bus.mem_addr, 0);
    check("midsweep_rst_busy", {bus.busy_clear, bus.cpu_stall, bus.mem_we}, 3'b111);
    check("midsweep_rst_host", {bus.host_ack, bus.host_rdata}, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    check_sweep();

    // Randomized: core on upper half, host on lower half, concurrently.
    fork
      begin
        logic hold = 1'b0;
        int ca;
        for (int i = 0; i < 600; i++) begin
          @(posedge CLK); #1;
          if (!hold) begin
            bus.cpu_en = ($urandom_range(0, 9) < 8);
            bus.cpu_we = $urandom_range(0, 1);
            ca = 64 + $urandom_range(0, 63);
            bus.cpu_addr = AW'(ca);
            bus.cpu_wdata = $urandom;
            if (bus.cpu_en && !bus.cpu_we) cpu_exp_q.push_back(exp_mem[ca]);
          end
          @(negedge CLK);
          hold = bus.cpu_en && bus.cpu_stall;
          if (bus.cpu_en && bus.cpu_we && !bus.cpu_stall) exp_mem[ca] = bus.cpu_wdata;
        end
        @(posedge CLK); #1;
        bus.cpu_en = 1'b0;
      end
      begin
        int hl;
        logic hw;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge CLK);
          d = $urandom;
          host_xact(1'($urandom_range(0, 1)), $urandom_range(0, 63), d, hl, hw);
          check("rand_host_latency_bound", hl <= LIMIT + 1, 1);
        end
      end
    join
    for (int a = 0; a < 64; a += 9) host_xact(1'b0, a, '0, lat, ack_we);

    // CLEAR_ON_RESET=0 instance: no sweep, core serviced in the first cycle.
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("nc_rst_busy_stall_we", {bus0.busy_clear, bus0.cpu_stall, bus0.mem_we}, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    bus0.cpu_en = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = AW'(7); bus0.cpu_wdata = 32'h77007700;
    @(negedge CLK);
    check("nc_first_write", {bus0.cpu_stall, bus0.mem_we, bus0.mem_addr}, {1'b0, 1'b1, 7'd7});
    @(posedge CLK); #1;
    bus0.cpu_we = 1'b0;
    @(negedge CLK);
    check("nc_readback", bus0.cpu_rdata, 32'h77007700);
    @(posedge CLK); #1;
    bus0.cpu_en = 1'b0;
    repeat (2) @(negedge CLK);

    check("host_queue_drained", host_exp_q.size(), 0);
    check("cpu_queue_drained", cpu_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Single-port access controller for the 128-word variable data memory (0x800–0x9FC window), sitting between the ARM core's data port, a host/debug port and the memory array's one read/write port. After reset it sequences a zero-fill sweep of the whole memory while stalling the core. It then arbitrates each cycle, with the core given priority and a starvation guard that forces a host slot. It replaces the direct core-to-memory hookup and the separate DIP read port in the top-level wrapper.

## Interface
- DEPTH, 128, memory words; address width AW = clog2(DEPTH)
- DW, 32, data width
- STARVE_LIMIT, 8, max consecutive cycles a pending host request may be denied (≥1)
- CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = go straight to RUN

- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-high
- cpu_en  in  1  core data access this cycle (decoded dec_DATA_VAR)
- cpu_we  in  1  core write strobe (MemWrite)
- cpu_addr  in  AW  word address (ALUResult[8:2])
- cpu_wdata  in  DW  core write data
- cpu_rdata  out  DW  core read data, combinational
- cpu_stall  out  1  core must hold PC and suppress its access
- host_req  in  1  host transaction request; held until host_ack
- host_we  in  1  host write (1) / read (0), stable while host_req
- host_addr  in  AW  host word address, stable while host_req
- host_wdata  in  DW  host write data, stable while host_req
- host_ack  out  1  one-cycle completion pulse, registered
- host_rdata  out  DW  host read data, registered, valid with host_ack and held afterwards
- busy_clear  out  1  zero-fill sweep in progress
- mem_we  out  1  memory write enable, synchronous write on CLK
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory combinational read data

## Operation
- States: CLEAR, RUN. On reset: CLEAR if CLEAR_ON_RESET, otherwise RUN.
- CLEAR behaviour:
  - Drives mem_we=1, mem_addr=clr_addr, mem_wdata=0; clr_addr increments each cycle.
  - When clr_addr=DEPTH-1 the state moves to RUN and clr_addr wraps to 0.
  - Host is never granted and core accesses are ignored.
- Per-cycle owner in RUN, in priority order:
  - FORCE: a pending host request with force_q=1.
  - CPU: cpu_en=1.
  - HOST: host pending with cpu_en=0.
  - IDLE: none of the above.
- "Host pending" = host_req=1 and host_ack=0. This prevents a re-grant in the ack cycle, so the host gets at most one access every 2 cycles.
- CPU owner: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, cpu_rdata=mem_rdata.
- HOST/FORCE owner: mem_addr=host_addr, mem_we=host_we, mem_wdata=host_wdata. mem_rdata is captured into host_rdata and host_ack=1 on the next cycle.
- In every non-CPU cycle cpu_rdata=0. In IDLE, mem_we=0.
- Starvation guard:
  - wait_cnt (width clog2(STARVE_LIMIT+1)) increments in each cycle where the host is pending and not granted; it saturates at STARVE_LIMIT.
  - wait_cnt clears on a host grant or when host_req=0.
  - force_q is registered; it is set on the edge where wait_cnt reaches STARVE_LIMIT and cleared after the forced grant.
- cpu_stall = (state==CLEAR) | force_q. During stall the core's access is not performed (no write).
- busy_clear = (state==CLEAR).
- host_req dropping before ack is illegal; the block's response is undefined except that no write occurs when host_req=0.

## Timing
- Reset values:
  - host_ack=0, host_rdata=0, wait_cnt=0, force_q=0, clr_addr=0.
  - busy_clear=cpu_stall=CLEAR_ON_RESET.
  - mem_we=CLEAR_ON_RESET (combinational from state).
- Sweep: after RESET falls, edge 1 writes addr 0 and edge DEPTH writes addr DEPTH-1. busy_clear and cpu_stall fall after edge DEPTH, so the core's first access is in cycle DEPTH+1.
- Host latency, idle core: granted in the cycle req is seen, ack in the next cycle. Total 1 cycle from first req cycle to ack.
- Host latency, core busy every cycle: STARVE_LIMIT denied cycles, then one forced cycle with cpu_stall=1, ack in the following cycle. Worst case STARVE_LIMIT+1 cycles to ack.
- Host write lands on the grant edge; a core read of the same address in a later cycle sees the new data.
- RESET asserted mid-sweep or mid-transaction: immediate return to reset values. A pending ack is lost, and the sweep restarts at addr 0.

## Test plan
- Reset with CLEAR_ON_RESET=1, memory preloaded with 0xDEADBEEF -> mem_we high for exactly 128 cycles, addresses 0..127, all words read 0 afterwards, cpu_stall low from cycle 129.
- RUN, cpu_en=0, host write addr 5 = 0x12345678 then host read addr 5 -> each host_ack one cycle after the first req cycle, host_rdata=0x12345678, no grant in either ack cycle.
- Core writes 0xA5A5A5A5 to addr 10, next cycle host reads 10 -> host_rdata=0xA5A5A5A5; core write then host write to the same address -> the later write wins.
- cpu_en=1 continuously with host read of addr 3 pending -> 8 denied cycles, cpu_stall high for exactly cycle 9 with no core write, host_ack in cycle 10, wait_cnt back to 0.
- RESET pulsed at sweep address 60 -> outputs return to reset values, sweep restarts from addr 0 and runs a full 128 cycles.
- CLEAR_ON_RESET=0 -> busy_clear=0 and cpu_stall=0 immediately after reset, core access serviced in the first cycle.
